ucie_fdi_state_ctrl: RTL and testbench
======================================

# ucie_fdi_state_ctrl

Adapter-side FDI link state controller. Consumes the Protocol Layer's FDI state/handshake requests (`lp_state_req`, `lp_rx_active_sts`, `lp_stallack`, `lp_linkerror`) and the physical-link status. It drives the matching FDI status outputs: `pl_state_sts`, `pl_rx_active_req`, `pl_stallreq`, `pl_inband_pres`, `pl_phyinrecenter`, `pl_trainerror`. It sits directly behind `ucie_fdi_interface`, between it and the RDI/physical side.

## Interface
- `TIMEOUT`, 1023: handshake timeout, in lclk cycles.
- `ERR_DWELL`, 16: minimum LINKERROR residency, in lclk cycles.

Ports:
- `lclk` in 1: clock
- `lrst_n` in 1: reset, asynchronous, active-low
- `lp_state_req` in 4: requested state (0000 NOP, 0001 Active, 1001 LinkReset, 1011 Retrain, 1100 Disabled; other codes treated as NOP)
- `lp_linkerror` in 1: Protocol Layer link error
- `lp_rx_active_sts` in 1: Protocol Layer receiver open
- `lp_stallack` in 1: stall acknowledge
- `phy_link_up` in 1: physical link trained
- `phy_retrain` in 1: physical side requests retrain
- `pl_state_sts` out 4: status (0000 Reset, 0001 Active, 1001 LinkReset, 1010 LinkError, 1011 Retrain, 1100 Disabled)
- `pl_inband_pres` out 1: registered copy of `phy_link_up`
- `pl_rx_active_req` out 1: request to open receive path
- `pl_stallreq` out 1: flush/stall request
- `pl_phyinrecenter` out 1: high while in RETRAIN
- `pl_trainerror` out 1: one-cycle pulse on timeout

## Operation
- States: RESET, RX_WAIT, ACTIVE, STALL, RETRAIN, LINKRESET, DISABLED, LINKERROR.
- `pl_state_sts` holds the last stable state through RX_WAIT and STALL. It changes only on entry to RESET, ACTIVE, RETRAIN, LINKRESET, DISABLED or LINKERROR.
- Global priority: `lp_linkerror`=1 in any state except LINKERROR forces LINKERROR and clears all request outputs.
- Global priority: `phy_link_up`=0 while in ACTIVE or STALL forces LINKERROR.
- RESET → RX_WAIT when `phy_link_up` and req=Active. On entry, set `pl_rx_active_req`=1.
- RX_WAIT → ACTIVE when `lp_rx_active_sts`=1. `pl_rx_active_req` stays high throughout ACTIVE.
- RX_WAIT timeout → LINKERROR.
- ACTIVE → STALL when req ∈ {Retrain, LinkReset, Disabled} or `phy_retrain`=1. The target is latched on entry. If more than one is present, priority is Disabled > LinkReset > Retrain (`phy_retrain` counts as Retrain).
- STALL: `pl_stallreq`=1.
  - On `lp_stallack`=1, go to the target, deassert `pl_stallreq` and deassert `pl_rx_active_req`.
  - Timeout → LINKERROR.
- RETRAIN → RX_WAIT when `phy_link_up`, `!phy_retrain` and req=Active.
- LINKRESET → RESET when req=Active.
- DISABLED is sticky until `lrst_n`.
- LINKERROR → RESET when the dwell counter ≥ `ERR_DWELL`, `lp_linkerror`=0 and req=Active.
- Timer:
  - Cleared on every state change.
  - Increments in RX_WAIT, STALL and LINKERROR.
  - Saturates at `TIMEOUT`; width $clog2(TIMEOUT+1).
  - Timeout fires when count==`TIMEOUT` and the exit condition is absent in the same cycle.
  - Timeout pulses `pl_trainerror` for exactly one cycle, coincident with the first LINKERROR cycle.

## Timing
- All outputs are registered.
- Reset values: `pl_state_sts`=0000; every other output 0.
- A request sampled at edge N is visible on outputs at edge N+1.
  - RESET→RX_WAIT: `pl_rx_active_req` high 1 cycle after `phy_link_up`&&req=Active.
  - RX_WAIT→ACTIVE: `pl_state_sts`=0001 1 cycle after `lp_rx_active_sts` is sampled high.
- Timeout and handshake completion in the same cycle: completion wins.
- `lp_linkerror` and `lp_stallack` in the same cycle: LINKERROR wins.
- `lrst_n` asserted mid-handshake: immediate asynchronous return to RESET with reset output values. The latched target and the timer are cleared.
- The STALL→target transition and the `pl_stallreq` drop occur on the same edge.

## Structure
- `ucie_fdi_pkg` holds:
  - state enum;
  - the 4-bit `lp_state_req` / `pl_state_sts` encodings as localparams;
  - the stall-target enum.
- Sub-module `ucie_fdi_timer`: saturating up-counter with clear, enable and a `TIMEOUT` compare output. It is instantiated once and shared by RX_WAIT, STALL and LINKERROR.

## Test plan
- Bring-up:
  - Stimulus: `phy_link_up`=1, req=0001, `lp_rx_active_sts` raised 3 cycles after `pl_rx_active_req`.
  - Required: `pl_rx_active_req` 1 cycle after the request; `pl_state_sts`=0001 exactly 1 cycle after the sts sample.
- Retrain via stall:
  - Stimulus: in ACTIVE, `phy_retrain`=1; `lp_stallack` after 5 cycles.
  - Required: `pl_stallreq` high 5 cycles; then `pl_state_sts`=1011, `pl_phyinrecenter`=1, `pl_rx_active_req`=0.
  - Then: `phy_retrain`=0, req=0001, sts ack → `pl_state_sts`=0001.
- Stall timeout:
  - Stimulus: TIMEOUT=8, req=1001, no `lp_stallack`.
  - Required: after 8 STALL cycles, `pl_state_sts`=1010 and a single-cycle `pl_trainerror`.
- Linkerror priority:
  - Stimulus: `lp_linkerror` and `lp_stallack` in the same cycle.
  - Required: LINKERROR, `pl_stallreq`=0.
  - Exit: no exit before 16 cycles even with req=0001; exit to RESET on cycle ≥16.
- Disabled:
  - Stimulus: req=1100 with stall ack.
  - Required: `pl_state_sts`=1100 held despite req=0001.
  - Then: `lrst_n` pulse → all outputs 0.
- Async reset in RX_WAIT:
  - Stimulus: `lrst_n` asserted mid-handshake.
  - Required: `pl_rx_active_req` drops without a clock edge.

Source files
------------

// File: rtl/ucie_fdi_pkg.sv
// Shared types and encodings for the adapter-side FDI state controller.
package ucie_fdi_pkg;

  // Internal controller states.
  typedef enum logic [2:0] {
    ST_RESET,
    ST_RX_WAIT,
    ST_ACTIVE,
    ST_STALL,
    ST_RETRAIN,
    ST_LINKRESET,
    ST_DISABLED,
    ST_LINKERROR
  } fdi_state_e;

  // Destination remembered while the stall handshake is in progress.
  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_RETRAIN,
    TGT_LINKRESET,
    TGT_DISABLED
  } stall_tgt_e;

  // lp_state_req encodings. Codes not listed here behave as NOP.
  localparam logic [3:0] REQ_NOP       = 4'b0000;
  localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
  localparam logic [3:0] REQ_LINKRESET = 4'b1001;
  localparam logic [3:0] REQ_RETRAIN   = 4'b1011;
  localparam logic [3:0] REQ_DISABLED  = 4'b1100;

  // pl_state_sts encodings.
  localparam logic [3:0] STS_RESET     = 4'b0000;
  localparam logic [3:0] STS_ACTIVE    = 4'b0001;
  localparam logic [3:0] STS_LINKRESET = 4'b1001;
  localparam logic [3:0] STS_LINKERROR = 4'b1010;
  localparam logic [3:0] STS_RETRAIN   = 4'b1011;
  localparam logic [3:0] STS_DISABLED  = 4'b1100;

  // Map a latched stall target to the state entered once the stall is acked.
  // A missing target means the handshake lost track, so treat it as an error.
  function automatic fdi_state_e tgt_to_state(input stall_tgt_e tgt);
    case (tgt)
      TGT_RETRAIN:   return ST_RETRAIN;
      TGT_LINKRESET: return ST_LINKRESET;
      TGT_DISABLED:  return ST_DISABLED;
      default:       return ST_LINKERROR;
    endcase
  endfunction

endpackage

// File: rtl/ucie_fdi_timer.sv
// Saturating handshake/dwell timer shared by RX_WAIT, STALL and LINKERROR.
module ucie_fdi_timer #(
  parameter int TIMEOUT = 1023,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);

  logic [W-1:0] count_reg;

  // Count up while enabled, stop at TIMEOUT, restart from zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != W'(TIMEOUT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count   = count_reg;
  assign expired = (count_reg == W'(TIMEOUT));

endmodule

// File: rtl/ucie_fdi_state_ctrl.sv
// Adapter-side FDI link state controller: turns Protocol Layer state
// requests and physical link status into registered FDI status outputs.
module ucie_fdi_state_ctrl
  import ucie_fdi_pkg::*;
#(
  parameter int TIMEOUT   = 1023,
  parameter int ERR_DWELL = 16
) (
  input  logic       lclk,
  input  logic       lrst_n,
  input  logic [3:0] lp_state_req,
  input  logic       lp_linkerror,
  input  logic       lp_rx_active_sts,
  input  logic       lp_stallack,
  input  logic       phy_link_up,
  input  logic       phy_retrain,
  output logic [3:0] pl_state_sts,
  output logic       pl_inband_pres,
  output logic       pl_rx_active_req,
  output logic       pl_stallreq,
  output logic       pl_phyinrecenter,
  output logic       pl_trainerror
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fdi_state_e state_reg, state_next;
  stall_tgt_e target_reg, target_next;

  logic [3:0] sts_reg, sts_next;
  logic       rx_req_reg, rx_req_next;
  logic       stall_reg, stall_next;
  logic       recenter_reg, recenter_next;
  logic       trainerr_reg, trainerr_next;
  logic       inband_reg;

  logic          timeout_hit;
  logic          dwell_met;
  logic          req_active;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_expired;
  logic [TW-1:0] timer_count;

  assign req_active = (lp_state_req == REQ_ACTIVE);
  assign dwell_met  = (32'(timer_count) >= $unsigned(ERR_DWELL));

  // Timer restarts on every state change and only runs in the waiting states.
  assign timer_clr = (state_next != state_reg);
  assign timer_en  = (state_reg == ST_RX_WAIT) || (state_reg == ST_STALL) ||
                     (state_reg == ST_LINKERROR);

  ucie_fdi_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (TW)
  ) u_timer (
    .clk     (lclk),
    .rst_n   (lrst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // Next-state selection: error conditions first, then per-state handshakes.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    timeout_hit = 1'b0;

    if (lp_linkerror && (state_reg != ST_LINKERROR)) begin
      state_next = ST_LINKERROR;
    end else if (!phy_link_up &&
                 ((state_reg == ST_ACTIVE) || (state_reg == ST_STALL))) begin
      state_next = ST_LINKERROR;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (phy_link_up && req_active) state_next = ST_RX_WAIT;
        end
        ST_RX_WAIT: begin
          // A completing handshake beats a timeout landing in the same cycle.
          if (lp_rx_active_sts) begin
            state_next = ST_ACTIVE;
          end else if (timer_expired) begin
            state_next  = ST_LINKERROR;
            timeout_hit = 1'b1;
          end
        end
        ST_ACTIVE: begin
          // Physical retrain requests rank with a Protocol Layer Retrain.
          if (lp_state_req == REQ_DISABLED) begin
            state_next  = ST_STALL;
            target_next = TGT_DISABLED;
          end else if (lp_state_req == REQ_LINKRESET) begin
            state_next  = ST_STALL;
            target_next = TGT_LINKRESET;
          end else if ((lp_state_req == REQ_RETRAIN) || phy_retrain) begin
            state_next  = ST_STALL;
            target_next = TGT_RETRAIN;
          end
        end
        ST_STALL: begin
          if (lp_stallack) begin
            state_next = tgt_to_state(target_reg);
          end else if (timer_expired) begin
            state_next  = ST_LINKERROR;
            timeout_hit = 1'b1;
          end
        end
        ST_RETRAIN: begin
          if (phy_link_up && !phy_retrain && req_active) state_next = ST_RX_WAIT;
        end
        ST_LINKRESET: begin
          if (req_active) state_next = ST_RESET;
        end
        ST_DISABLED: begin
          state_next = ST_DISABLED;
        end
        ST_LINKERROR: begin
          if (dwell_met && !lp_linkerror && req_active) state_next = ST_RESET;
        end
        default: begin
          state_next = ST_LINKERROR;
        end
      endcase
    end

    // The target only has meaning while the stall handshake is open.
    if (state_next != ST_STALL) target_next = TGT_NONE;
  end

  // Output values for the cycle after the edge, derived from the next state.
  always_comb begin
    sts_next      = sts_reg;
    rx_req_next   = 1'b0;
    stall_next    = 1'b0;
    recenter_next = 1'b0;
    trainerr_next = timeout_hit;

    case (state_next)
      ST_RESET:     sts_next = STS_RESET;
      ST_ACTIVE:    sts_next = STS_ACTIVE;
      ST_RETRAIN:   sts_next = STS_RETRAIN;
      ST_LINKRESET: sts_next = STS_LINKRESET;
      ST_DISABLED:  sts_next = STS_DISABLED;
      ST_LINKERROR: sts_next = STS_LINKERROR;
      default:      sts_next = sts_reg;  // RX_WAIT and STALL keep the last stable status
    endcase

    rx_req_next   = (state_next == ST_RX_WAIT) || (state_next == ST_ACTIVE) ||
                    (state_next == ST_STALL);
    stall_next    = (state_next == ST_STALL);
    recenter_next = (state_next == ST_RETRAIN);
  end

  // State, latched target and all outputs are registered; reset is immediate.
  always_ff @(posedge lclk or negedge lrst_n) begin
    if (!lrst_n) begin
      state_reg    <= ST_RESET;
      target_reg   <= TGT_NONE;
      sts_reg      <= STS_RESET;
      rx_req_reg   <= 1'b0;
      stall_reg    <= 1'b0;
      recenter_reg <= 1'b0;
      trainerr_reg <= 1'b0;
      inband_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      sts_reg      <= sts_next;
      rx_req_reg   <= rx_req_next;
      stall_reg    <= stall_next;
      recenter_reg <= recenter_next;
      trainerr_reg <= trainerr_next;
      inband_reg   <= phy_link_up;
    end
  end

  assign pl_state_sts     = sts_reg;
  assign pl_inband_pres   = inband_reg;
  assign pl_rx_active_req = rx_req_reg;
  assign pl_stallreq      = stall_reg;
  assign pl_phyinrecenter = recenter_reg;
  assign pl_trainerror    = trainerr_reg;

endmodule

// File: tb/tb_ucie_fdi_state_ctrl.sv
// Directed bench for ucie_fdi_state_ctrl. A second instance with a short
// timeout shares the stimulus and is used for the timeout boundary cases.
module tb_ucie_fdi_state_ctrl;

  logic       lclk = 1'b0;
  logic       lrst_n = 1'b0;
  logic [3:0] lp_state_req = 4'b0000;
  logic       lp_linkerror = 1'b0;
  logic       lp_rx_active_sts = 1'b0;
  logic       lp_stallack = 1'b0;
  logic       phy_link_up = 1'b0;
  logic       phy_retrain = 1'b0;

  logic [3:0] sts;
  logic       inb, rxr, stl, rec, ter;
  logic [3:0] sts_t8;
  logic       inb_t8, rxr_t8, stl_t8, rec_t8, ter_t8;

  int tests = 0;
  int fails = 0;

  always #5 lclk = ~lclk;

  ucie_fdi_state_ctrl dut (
    .lclk             (lclk),
    .lrst_n           (lrst_n),
    .lp_state_req     (lp_state_req),
    .lp_linkerror     (lp_linkerror),
    .lp_rx_active_sts (lp_rx_active_sts),
    .lp_stallack      (lp_stallack),
    .phy_link_up      (phy_link_up),
    .phy_retrain      (phy_retrain),
    .pl_state_sts     (sts),
    .pl_inband_pres   (inb),
    .pl_rx_active_req (rxr),
    .pl_stallreq      (stl),
    .pl_phyinrecenter (rec),
    .pl_trainerror    (ter)
  );

  ucie_fdi_state_ctrl #(.TIMEOUT(8), .ERR_DWELL(16)) dut_t8 (
    .lclk             (lclk),
    .lrst_n           (lrst_n),
    .lp_state_req     (lp_state_req),
    .lp_linkerror     (lp_linkerror),
    .lp_rx_active_sts (lp_rx_active_sts),
    .lp_stallack      (lp_stallack),
    .phy_link_up      (phy_link_up),
    .phy_retrain      (phy_retrain),
    .pl_state_sts     (sts_t8),
    .pl_inband_pres   (inb_t8),
    .pl_rx_active_req (rxr_t8),
    .pl_stallreq      (stl_t8),
    .pl_phyinrecenter (rec_t8),
    .pl_trainerror    (ter_t8)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge lclk);
    #1;
    check("rst_sts", sts, 4'b0000);
    check("rst_inband", inb, 1'b0);
    check("rst_rxreq", rxr, 1'b0);
    check("rst_stallreq", stl, 1'b0);
    check("rst_recenter", rec, 1'b0);
    check("rst_trainerr", ter, 1'b0);
    lrst_n = 1'b1;

    // Bring-up: RESET -> RX_WAIT -> ACTIVE
    phy_link_up  = 1'b1;
    lp_state_req = 4'b0001;
    tick();
    check("bringup_rxreq", rxr, 1'b1);
    check("bringup_sts_hold", sts, 4'b0000);
    check("bringup_inband", inb, 1'b1);
    tick();
    tick();
    check("bringup_sts_wait", sts, 4'b0000);
    lp_rx_active_sts = 1'b1;
    tick();
    check("bringup_active", sts, 4'b0001);
    check("bringup_rxreq_active", rxr, 1'b1);

    // Retrain through a five-cycle stall
    phy_retrain = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("retrain_stallreq", stl, 1'b1);
    end
    check("retrain_sts_hold", sts, 4'b0001);
    check("retrain_rxreq_hold", rxr, 1'b1);
    lp_stallack = 1'b1;
    tick();
    lp_stallack      = 1'b0;
    lp_rx_active_sts = 1'b0;
    check("retrain_sts", sts, 4'b1011);
    check("retrain_recenter", rec, 1'b1);
    check("retrain_rxreq_drop", rxr, 1'b0);
    check("retrain_stall_drop", stl, 1'b0);
    phy_retrain = 1'b0;
    tick();
    check("retrain_rxwait_rxreq", rxr, 1'b1);
    check("retrain_rxwait_recenter", rec, 1'b0);
    check("retrain_rxwait_sts", sts, 4'b1011);
    lp_rx_active_sts = 1'b1;
    tick();
    check("retrain_reactive", sts, 4'b0001);

    // Link error and stall ack together: link error wins
    lp_state_req = 4'b1001;
    tick();
    check("lerr_stallreq", stl, 1'b1);
    lp_linkerror = 1'b1;
    lp_stallack  = 1'b1;
    tick();
    check("lerr_sts", sts, 4'b1010);
    check("lerr_stall_drop", stl, 1'b0);
    check("lerr_rxreq_drop", rxr, 1'b0);
    check("lerr_no_trainerr", ter, 1'b0);
    lp_linkerror = 1'b0;
    lp_stallack  = 1'b0;
    lp_state_req = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("lerr_dwell_hold", sts, 4'b1010);
    end
    tick();
    check("lerr_exit_reset", sts, 4'b0000);

    // Disabled is sticky until reset
    tick();
    check("dis_rxwait_rxreq", rxr, 1'b1);
    tick();
    check("dis_active", sts, 4'b0001);
    lp_state_req = 4'b1100;
    tick();
    check("dis_stallreq", stl, 1'b1);
    lp_stallack = 1'b1;
    tick();
    lp_stallack = 1'b0;
    check("dis_sts", sts, 4'b1100);
    check("dis_rxreq_drop", rxr, 1'b0);
    lp_state_req = 4'b0001;
    repeat (3) tick();
    check("dis_sticky", sts, 4'b1100);
    lrst_n = 1'b0;
    #1;
    check("dis_rst_sts", sts, 4'b0000);
    check("dis_rst_inband", inb, 1'b0);
    check("dis_rst_rxreq", rxr, 1'b0);
    check("dis_rst_stallreq", stl, 1'b0);
    check("dis_rst_recenter", rec, 1'b0);
    check("dis_rst_trainerr", ter, 1'b0);
    #2;
    lrst_n = 1'b1;

    // Asynchronous reset in the middle of the RX_WAIT handshake
    lp_rx_active_sts = 1'b0;
    tick();
    check("arst_rxreq_before", rxr, 1'b1);
    #2;
    lrst_n = 1'b0;
    #1;
    check("arst_rxreq_drop", rxr, 1'b0);
    check("arst_sts", sts, 4'b0000);
    #1;
    lrst_n = 1'b1;

    // Short-timeout instance: completion in the timeout cycle wins
    tick();
    check("t8_rxwait_rxreq", rxr_t8, 1'b1);
    repeat (8) tick();
    check("t8_rxwait_hold", sts_t8, 4'b0000);
    check("t8_rxwait_rxreq_hold", rxr_t8, 1'b1);
    lp_rx_active_sts = 1'b1;
    tick();
    check("t8_complete_wins", sts_t8, 4'b0001);
    check("t8_complete_no_trainerr", ter_t8, 1'b0);

    // Short-timeout instance: stall with no ack times out
    lp_state_req = 4'b1001;
    tick();
    check("t8_stall_enter", stl_t8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t8_stall_hold", stl_t8, 1'b1);
    end
    check("t8_no_early_trainerr", ter_t8, 1'b0);
    tick();
    check("t8_timeout_sts", sts_t8, 4'b1010);
    check("t8_timeout_trainerr", ter_t8, 1'b1);
    check("t8_timeout_stall_drop", stl_t8, 1'b0);
    check("t8_timeout_rxreq_drop", rxr_t8, 1'b0);
    check("long_timeout_still_stall", stl, 1'b1);
    tick();
    check("t8_trainerr_pulse_end", ter_t8, 1'b0);
    check("t8_linkerror_hold", sts_t8, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
